// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio path constants, bank encodings and sequencer states
package audio_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 10;

  localparam logic [1:0] BANK_BYPASS = 2'd0;
  localparam logic [1:0] BANK_AVG    = 2'd1;
  localparam logic [1:0] BANK_LP     = 2'd2;
  localparam logic [1:0] BANK_BOOST  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/filter_coeffs.sv
// rtl/filter_coeffs.sv - combinational (bank, tap) to signed coefficient lookup
module filter_coeffs
  import audio_pkg::*;
#(
  parameter int NTAPS  = 31,
  parameter int COEF_W = DEF_COEF_W,
  parameter int KW     = $clog2(NTAPS)
) (
  input  logic [1:0]               bank,
  input  logic [KW-1:0]            k,
  output logic signed [COEF_W-1:0] coef
);

  // Largest positive coefficient, i.e. just under unity gain
  localparam int CMAX = 2**(COEF_W-1) - 1;

  int ki;
  int mirror;

  // Low-pass bank is a triangular window 2*(distance-to-nearest-end + 1), unity DC gain at 31 taps
  always_comb begin
    coef   = '0;
    ki     = int'(k);
    mirror = NTAPS - 1 - ki;
    if (ki < NTAPS) begin
      case (bank)
        BANK_AVG:   coef = COEF_W'(16);
        BANK_LP:    coef = COEF_W'(2 * (((ki < mirror) ? ki : mirror) + 1));
        BANK_BOOST: coef = (ki < 2) ? COEF_W'(CMAX) : '0;
        default:    coef = '0;
      endcase
    end
  end

endmodule

// File: rtl/filter_sequencer.sv
// rtl/filter_sequencer.sv - time-multiplexed FIR controller with circular delay line and shared MAC
module filter_sequencer
  import audio_pkg::*;
#(
  parameter int NTAPS  = 31,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic [1:0]        switch,
  input  logic [DATA_W-1:0] audio_in,
  output logic [DATA_W-1:0] audio_out,
  output logic              done,
  output logic              busy,
  output logic              overrun
);

  localparam int KW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  seq_state_t state, state_nxt;

  logic [DATA_W-1:0]        dline [NTAPS];
  logic [KW-1:0]            wp;
  logic [KW-1:0]            k;
  logic [KW-1:0]            rd_idx;
  logic [1:0]               bank;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        sat_out;
  logic                     start;

  filter_coeffs #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .KW     (KW)
  ) u_coeffs (
    .bank (bank),
    .k    (k),
    .coef (coef)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a sample is only accepted from IDLE
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (ready) begin
          start     = 1'b1;
          state_nxt = (switch == BANK_BYPASS) ? OUT : MAC;
        end
      end
      MAC:     if (k == KW'(NTAPS - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tap k reads the sample written k strobes ago, wrapping the circular pointer
  always_comb begin
    if (k <= wp) rd_idx = wp - k;
    else         rd_idx = wp + KW'(NTAPS) - k;
    prod = PROD_W'(coef) * PROD_W'($signed(dline[rd_idx]));
  end

  // Floor-scale the accumulator back to sample range and clamp
  always_comb begin
    acc_shr = acc >>> (COEF_W - 1);
    if (acc_shr > SAT_MAX)      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_shr < SAT_MIN) sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    else                        sat_out = acc_shr[DATA_W-1:0];
  end

  // Delay line, pointer, accumulator and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wp        <= '0;
      k         <= '0;
      acc       <= '0;
      bank      <= BANK_BYPASS;
      audio_out <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= ready && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            dline[wp] <= audio_in;
            bank      <= switch;
            acc       <= '0;
            k         <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + 1'b1;
        end
        OUT: begin
          audio_out <= (bank == BANK_BYPASS) ? dline[wp] : sat_out;
          done      <= 1'b1;
          wp        <= (wp == KW'(NTAPS - 1)) ? '0 : wp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_filter_sequencer.sv
// tb/tb_filter_sequencer.sv - randomized self-checking bench against a sample-history FIR model
module tb_filter_sequencer;

  localparam int NTAPS  = 31;
  localparam int DATA_W = 8;
  localparam int COEF_W = 10;

  logic              clock;
  logic              reset;
  logic              ready;
  logic [1:0]        switch;
  logic [DATA_W-1:0] audio_in;
  logic [DATA_W-1:0] audio_out;
  logic              done;
  logic              busy;
  logic              overrun;

  int errors = 0;
  int checks = 0;
  int hist[$];

  filter_sequencer #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .switch    (switch),
    .audio_in  (audio_in),
    .audio_out (audio_out),
    .done      (done),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_coef(int b, int k);
    int m;
    if (k >= NTAPS) return 0;
    m = (k < NTAPS - 1 - k) ? k : NTAPS - 1 - k;
    case (b)
      1:       return 16;
      2:       return 2 * (m + 1);
      3:       return (k < 2) ? 511 : 0;
      default: return 0;
    endcase
  endfunction

  // Output for the newest accepted sample: convolution over all samples since reset
  function automatic int ref_out(int b);
    int n, sum, y;
    n = hist.size() - 1;
    if (b == 0) return hist[n];
    sum = 0;
    for (int k = 0; k < NTAPS; k++)
      if (n - k >= 0) sum += ref_coef(b, k) * hist[n - k];
    y = sum >>> (COEF_W - 1);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    ready = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 4)) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge where done is high (lat = -1 on timeout)
  task automatic do_sample(input int s, input int sw, output int lat, output int got);
    ready    = 1'b1;
    audio_in = DATA_W'(s);
    switch   = 2'(sw);
    hist.push_back(s);
    @(negedge clock);
    ready = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    got = int'($signed(audio_out));
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (audio_out !== '0) begin errors++; $display("FAIL reset_audio_out: got %0d expected 0", audio_out); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_bypass();
    int lat, got;
    do_sample(-57, 0, lat, got);
    checks++; if (lat != 1)   begin errors++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
    checks++; if (got != -57) begin errors++; $display("FAIL bypass_out: got %0d expected -57", got); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bypass_busy_done: got %b expected 1", busy); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bypass_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_impulse();
    int lat, got, exp;
    apply_reset(2);
    for (int i = 0; i < 32; i++) begin
      do_sample((i == 0) ? 127 : 0, 1, lat, got);
      exp = (i < 31) ? 3 : 0;
      checks++; if (got != exp) begin errors++; $display("FAIL impulse_out[%0d]: got %0d expected %0d", i, got, exp); end
      checks++; if (lat != NTAPS + 1) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, lat, NTAPS + 1); end
      idle_gap();
    end
  endtask

  task automatic test_dc();
    int lat, got, exp;
    apply_reset(2);
    for (int i = 0; i < 35; i++) begin
      do_sample(127, 1, lat, got);
      exp = ref_out(1);
      if (i >= 30) exp = 123;
      checks++; if (got != exp) begin errors++; $display("FAIL dc_out[%0d]: got %0d expected %0d", i, got, exp); end
      checks++; if (lat != NTAPS + 1) begin errors++; $display("FAIL dc_latency[%0d]: got %0d expected %0d", i, lat, NTAPS + 1); end
      idle_gap();
    end
  endtask

  task automatic test_saturation();
    int lat, got, exp;
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      do_sample(127, 3, lat, got);
      exp = (i == 0) ? 126 : 127;
      checks++; if (got != exp) begin errors++; $display("FAIL sat_pos[%0d]: got %0d expected %0d", i, got, exp); end
      idle_gap();
    end
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      do_sample(-128, 3, lat, got);
      checks++; if (got != -128) begin errors++; $display("FAIL sat_neg[%0d]: got %0d expected -128", i, got); end
      idle_gap();
    end
  endtask

  task automatic test_random_banks();
    int lat, got, exp, b;
    apply_reset(2);
    for (int i = 0; i < 60; i++) begin
      b = (i < 20) ? 2 : int'($urandom_range(0, 3));
      do_sample(rand_sample(), b, lat, got);
      exp = ref_out(b);
      checks++; if (got != exp) begin errors++; $display("FAIL random_out[%0d] bank %0d: got %0d expected %0d", i, b, got, exp); end
      checks++; if (lat != ((b == 0) ? 1 : NTAPS + 1)) begin errors++; $display("FAIL random_latency[%0d] bank %0d: got %0d", i, b, lat); end
      idle_gap();
    end
  endtask

  task automatic test_overrun_latch();
    int lat, got, exp, a;
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      do_sample(rand_sample(), 1, lat, got);
      idle_gap();
    end
    a = rand_sample();
    ready    = 1'b1;
    audio_in = DATA_W'(a);
    switch   = 2'd1;
    hist.push_back(a);
    @(negedge clock);
    ready  = 1'b0;
    switch = 2'd3;
    lat    = 0;
    repeat (5) begin @(negedge clock); lat++; end
    ready    = 1'b1;
    audio_in = DATA_W'(100);
    @(negedge clock); lat++;
    ready = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_mac_pulse: got %b expected 1", overrun); end
    @(negedge clock); lat++;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_mac_width: got %b expected 0", overrun); end
    while (lat < NTAPS) begin @(negedge clock); lat++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy_out: got %b expected 1", busy); end
    ready    = 1'b1;
    audio_in = DATA_W'(-100);
    @(negedge clock); lat++;
    ready = 1'b0;
    checks++; if (done !== 1'b1)    begin errors++; $display("FAIL latch_done_at_%0d: got %b expected 1", lat, done); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_out_pulse: got %b expected 1", overrun); end
    got = int'($signed(audio_out));
    exp = ref_out(1);
    checks++; if (got != exp) begin errors++; $display("FAIL latch_out: got %0d expected %0d", got, exp); end
    @(negedge clock);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_out_width: got %b expected 0", overrun); end
    do_sample(rand_sample(), 1, lat, got);
    exp = ref_out(1);
    checks++; if (got != exp) begin errors++; $display("FAIL overrun_dropped: got %0d expected %0d", got, exp); end
  endtask

  task automatic test_back_to_back();
    int lat, got, exp, b;
    apply_reset(2);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      b = int'($urandom_range(1, 3));
      do_sample(rand_sample(), b, lat, got);
      exp = ref_out(b);
      checks++; if (got != exp) begin errors++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, got, exp); end
      checks++; if (lat != NTAPS + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, NTAPS + 1); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun[%0d]: got %b expected 0", i, overrun); end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_mac();
    int lat, got, seen_done;
    int prime[3] = '{100, -90, 77};
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      do_sample(prime[i], 1, lat, got);
      idle_gap();
    end
    ready    = 1'b1;
    audio_in = DATA_W'(50);
    switch   = 2'd1;
    @(negedge clock);
    ready = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    hist.delete();
    checks++; if (audio_out !== '0) begin errors++; $display("FAIL midmac_audio_out: got %0d expected 0", audio_out); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midmac_busy: got %b expected 0", busy); end
    seen_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midmac_no_done: got %0d done pulses expected 0", seen_done); end
    for (int i = 0; i < 6; i++) begin
      do_sample((i == 0) ? 127 : 0, 1, lat, got);
      checks++; if (got != 3) begin errors++; $display("FAIL midmac_impulse[%0d]: got %0d expected 3", i, got); end
      idle_gap();
    end
  endtask

  initial begin
    reset    = 1'b1;
    ready    = 1'b0;
    switch   = 2'd0;
    audio_in = '0;
    test_reset();
    test_bypass();
    test_impulse();
    test_dc();
    test_saturation();
    test_random_banks();
    test_overrun_latch();
    test_back_to_back();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
